// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix stream host.
// Holds the element/word geometry, the host FSM state type and a helper
// that places one element byte into a packed 2x2 operand word.
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 4;
    localparam int WORD_W = ELEM_W * N_ELEM;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    // Element 0 (m00) lives in the most significant byte.
    function automatic logic [WORD_W-1:0] put_elem(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        idx,
        input logic [ELEM_W-1:0] elem
    );
        logic [WORD_W-1:0] res;
        res = word;
        case (idx)
            2'd0:    res[31:24] = elem;
            2'd1:    res[23:16] = elem;
            2'd2:    res[15:8]  = elem;
            2'd3:    res[7:0]   = elem;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mm_byte_serializer.sv
// 32-to-8 shift register with a valid/ready output handshake.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   load          : capture load_data and start presenting it (MSB byte first)
//   load_data     : packed result word
//   out_ready     : downstream accepts out_data
//   out_data      : current byte (registered)
//   out_valid     : out_data is valid (registered)
//   last          : the final byte transfers this cycle
module mm_byte_serializer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_valid,
    output logic              last
);

    logic [WORD_W-1:0] shreg_r;
    logic [1:0]        cnt_r;
    logic              valid_r;
    logic              xfer_s;

    assign xfer_s    = valid_r && out_ready;
    assign last      = xfer_s && (cnt_r == 2'(N_ELEM - 1));
    assign out_data  = shreg_r[WORD_W-1 -: ELEM_W];
    assign out_valid = valid_r;

    // Shift register: load a word, then shift one byte out per accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_r <= '0;
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else if (load) begin
            shreg_r <= load_data;
            cnt_r   <= 2'd0;
            valid_r <= 1'b1;
        end else if (xfer_s) begin
            shreg_r <= {shreg_r[WORD_W-ELEM_W-1:0], {ELEM_W{1'b0}}};
            cnt_r   <= cnt_r + 2'd1;
            valid_r <= (cnt_r != 2'(N_ELEM - 1));
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/matrix_stream_host.sv
// Host for a 2x2 matrix multiplier: collects 8 operand bytes, launches the
// multiplier, waits for its result (with a hang timeout) and streams the
// 4 result bytes back out.
// Ports:
//   clk, rst                : clock, synchronous active-low reset
//   in_data/in_valid/in_ready : operand byte stream (A bytes 0-3, B bytes 4-7)
//   mm_a, mm_b, mm_start    : packed operands and launch pulse to the multiplier
//   mm_done, mm_res         : multiplier completion (pulse or level) and product
//   out_data/out_valid/out_ready : result byte stream
//   busy                    : high whenever not loading operands
//   err                     : sticky multiplier timeout flag
module matrix_stream_host
    import matrix_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] mm_a,
    output logic [WORD_W-1:0] mm_b,
    output logic              mm_start,
    input  logic              mm_done,
    input  logic [WORD_W-1:0] mm_res,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t            state_r, state_s;
    logic [2:0]        byte_cnt_r;
    logic [TW-1:0]     tmo_cnt_r;
    logic [WORD_W-1:0] mm_a_r, mm_b_r;
    logic              in_ready_r, mm_start_r, busy_r, err_r;
    logic              take_s, capture_s, tmo_last_s, timeout_s, ser_last_s;

    assign take_s     = (state_r == ST_LOAD) && in_valid && in_ready_r;
    assign capture_s  = (state_r == ST_WAIT) && mm_done;
    assign tmo_last_s = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    // A done in the final timeout cycle takes precedence over the timeout.
    assign timeout_s  = (state_r == ST_WAIT) && !mm_done && tmo_last_s;

    assign in_ready = in_ready_r;
    assign mm_a     = mm_a_r;
    assign mm_b     = mm_b_r;
    assign mm_start = mm_start_r;
    assign busy     = busy_r;
    assign err      = err_r;

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (take_s && (byte_cnt_r == 3'd7)) state_s = ST_START;
                else                                state_s = ST_LOAD;
            end
            ST_START: state_s = ST_WAIT;
            ST_WAIT: begin
                if (mm_done)        state_s = ST_SEND;
                else if (tmo_last_s) state_s = ST_LOAD;
                else                state_s = ST_WAIT;
            end
            ST_SEND: begin
                if (ser_last_s) state_s = ST_LOAD;
                else            state_s = ST_SEND;
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // State, counters, operand registers and registered status outputs.
    // Status outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_LOAD;
            byte_cnt_r <= 3'd0;
            tmo_cnt_r  <= '0;
            mm_a_r     <= '0;
            mm_b_r     <= '0;
            in_ready_r <= 1'b0;
            mm_start_r <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == ST_LOAD);
            mm_start_r <= (state_s == ST_START);
            busy_r     <= (state_s != ST_LOAD);

            if (take_s) begin
                byte_cnt_r <= byte_cnt_r + 3'd1;
                if (!byte_cnt_r[2]) mm_a_r <= put_elem(mm_a_r, byte_cnt_r[1:0], in_data);
                else                mm_b_r <= put_elem(mm_b_r, byte_cnt_r[1:0], in_data);
            end else if (timeout_s) begin
                byte_cnt_r <= 3'd0;
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end

            if ((state_r == ST_WAIT) && !mm_done && !tmo_last_s) tmo_cnt_r <= tmo_cnt_r + TW'(1);
            else                                                 tmo_cnt_r <= '0;

            if (timeout_s) err_r <= 1'b1;
            else           err_r <= err_r;
        end
    end

    // The serializer's shift register doubles as the captured-result register.
    mm_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (capture_s),
        .load_data (mm_res),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .last      (ser_last_s)
    );

endmodule

// File: doc/matrix_stream_host.md
MATRIX_STREAM_HOST -- requirements
Module: matrix_stream_host

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of WAIT cycles before the multiplier is declared hung.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous, active-low.
REQ-004 The block SHALL have port in_data, input, 8 bits: the operand element byte.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data.
REQ-007 The block SHALL have ports mm_a and mm_b, output, 32 bits each: the packed 2x2 operands {m00,m01,m10,m11}, with m00 in bits [31:24].
REQ-008 The block SHALL have port mm_start, output, 1 bit: a one-cycle launch pulse to the multiplier.
REQ-009 The block SHALL have port mm_done, input, 1 bit: the multiplier result is valid; either a pulse or a held level is accepted.
REQ-010 The block SHALL have port mm_res, input, 32 bits: the packed 2x2 product.
REQ-011 The block SHALL have port out_data, output, 8 bits: the result element byte.
REQ-012 The block SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: the result handshake.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except LOAD.
REQ-014 The block SHALL have port err, output, 1 bit: a sticky timeout flag.

Function
REQ-015 The FSM SHALL have four states, LOAD, START, WAIT and SEND, and SHALL enter LOAD out of reset.
REQ-016 In LOAD, in_ready SHALL be 1; a byte transfers when in_valid and in_ready are both high; a 3-bit counter SHALL place bytes 0-3 into mm_a [31:24] down to [7:0] and bytes 4-7 into mm_b in the same order.
REQ-017 The transfer of byte 7 SHALL move the FSM to START on the next cycle, and in_ready SHALL be 0 from that cycle on.
REQ-018 START SHALL last exactly one cycle with mm_start=1, then go to WAIT; mm_a and mm_b SHALL stay stable from START until the FSM re-enters LOAD.
REQ-019 In WAIT, the first cycle with mm_done=1 SHALL capture mm_res into a result register, clear the timeout counter and go to SEND.
REQ-020 In WAIT, a counter SHALL increment each cycle; after TIMEOUT_CYCLES cycles without mm_done, the block SHALL set err=1 and return to LOAD with the byte counter at 0.
REQ-021 If mm_done arrives in the final timeout cycle, mm_done SHALL win: no err, go to SEND.
REQ-022 In SEND, out_valid SHALL be 1 and out_data SHALL present the result bytes [31:24], [23:16], [15:8], [7:0] in turn, advancing one byte per cycle in which out_valid and out_ready are both high.
REQ-023 While out_ready=0, out_data and out_valid SHALL hold stable.
REQ-024 Transfer of the 4th result byte SHALL return the FSM to LOAD on the next cycle.
REQ-025 A zero-latency sequence SHALL take 8 load cycles, 1 START cycle, at least 1 WAIT cycle and 4 SEND cycles.
REQ-026 Arithmetic overflow SHALL be the multiplier's concern; this block SHALL pass all bytes unmodified.
REQ-027 mm_done asserted outside WAIT SHALL be ignored.
REQ-028 in_valid asserted outside LOAD SHALL be ignored, with no byte consumed.

Reset
REQ-029 When rst=0 at a clock edge, the block SHALL set state=LOAD, clear all counters, and set mm_a=0, mm_b=0, mm_start=0, out_valid=0, out_data=0, err=0, busy=0, and in_ready=0 for that cycle.
REQ-030 Reset mid-operation, in any state, SHALL discard partial operands and results, with no mm_start or out_valid glitch.
REQ-031 err SHALL clear only by reset.

Structure
REQ-032 The shared package matrix_pkg SHALL hold ELEM_W=8, N_ELEM=4, and the FSM state typedef.
REQ-033 One sub-module is natural: mm_byte_serializer, a 32-to-8 shift register with valid/ready, used for SEND.

Verification
REQ-034 Scenario: load 01,02,03,04,05,06,07,08 with a model multiplier (done after 8 cycles) -> mm_a=0x01020304, mm_b=0x05060708, one mm_start pulse, out bytes 0x13,0x16,0x2B,0x32.
REQ-035 Scenario: the same with out_ready toggling 1,0,0,1 -> each byte held stable while stalled, output sequence unchanged, then return to LOAD.
REQ-036 Scenario: in_valid with random gaps, 50% duty -> identical mm_a/mm_b; mm_start only after the 8th byte.
REQ-037 Scenario: multiplier never raises mm_done -> err=1 exactly TIMEOUT_CYCLES cycles after START, FSM in LOAD, and the next 8 bytes produce a correct result.
REQ-038 Scenario: rst=0 after byte 5, then a full new load -> result computed only from the post-reset bytes, and mm_start asserted once.
REQ-039 Scenario: mm_done held high continuously -> exactly one capture per operation, and a back-to-back second operation also correct.
